dead_time_generator: RTL and testbench

Downstream stage of the PWM modulator. Consumes the complementary PWM_High/PWM_Low pair and produces two non-overlapping gate-drive signals for a half-bridge. Between any turn-off of one gate and turn-on of the other it inserts a programmable dead time. It also provides an enable and a latched fault shutdown.

---
 rtl/dead_time_pkg.sv | 41 ++++
 rtl/dead_time_counter.sv | 29 ++
 rtl/dead_time_generator.sv | 107 ++++++++++
 tb/tb_dead_time_generator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dead_time_pkg.sv
// Shared types and constants for the half-bridge dead-time generator.
// One-hot FSM state, request decode type, and DEAD_TIME range constants.
package dead_time_pkg;

  localparam int DEAD_TIME_DEF = 4;
  localparam int DEAD_TIME_MIN = 1;
  localparam int DEAD_TIME_MAX = 255;

  localparam int B_IDLE  = 0;
  localparam int B_HIGH  = 1;
  localparam int B_LOW   = 2;
  localparam int B_DEAD  = 3;
  localparam int B_FAULT = 4;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_HIGH_ON = 5'b00010,
    S_LOW_ON  = 5'b00100,
    S_DEAD    = 5'b01000,
    S_FAULT   = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } req_t;

  function automatic state_t req_target(
    input req_t req
  );
    state_t s;
    case (req)
      REQ_HIGH: s = S_HIGH_ON;
      REQ_LOW:  s = S_LOW_ON;
      default:  s = S_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dead_time_counter.sv
// Loadable down-counter that times the dead interval.
// Ports: i_clk, i_rst_n, i_load, i_load_val, i_dec, o_zero.
module dead_time_counter #(
  parameter int         W       = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dead_time_generator.sv
// Turns a complementary PWM pair into non-overlapping half-bridge gates.
// In: Clock, Reset, PWM_High/Low, Enable, Fault, Fault_Clear. Out: gates, Dead_Active, Fault_Latched.
module dead_time_generator
  import dead_time_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic PWM_High,
  input  logic PWM_Low,
  input  logic Enable,
  input  logic Fault,
  input  logic Fault_Clear,
  output logic Gate_High,
  output logic Gate_Low,
  output logic Dead_Active,
  output logic Fault_Latched
);

  localparam int CW = $clog2(DEAD_TIME + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DEAD_TIME - 1);

  logic   r_hi;
  logic   r_lo;
  logic   r_en;
  logic   r_flt;
  state_t r_state;
  req_t   w_req;
  logic   w_load;
  logic   w_dec;
  logic   w_zero;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_hi  <= 1'b0;
      r_lo  <= 1'b0;
      r_en  <= 1'b0;
      r_flt <= 1'b0;
    end else begin
      r_hi  <= PWM_High;
      r_lo  <= PWM_Low;
      r_en  <= Enable;
      r_flt <= Fault;
    end
  end

  // Equal pairs (00/11) and Enable=0 both decode to NONE.
  always_comb begin
    w_req = REQ_NONE;
    if (r_en && r_hi && !r_lo) begin
      w_req = REQ_HIGH;
    end else if (r_en && !r_hi && r_lo) begin
      w_req = REQ_LOW;
    end
  end

  // Load on every entry into DEAD; count down only while in DEAD.
  always_comb begin
    w_load = 1'b0;
    w_dec  = 1'b0;
    if (!r_flt) begin
      unique case (1'b1)
        r_state[B_HIGH]:  w_load = (w_req != REQ_HIGH);
        r_state[B_LOW]:   w_load = (w_req != REQ_LOW);
        r_state[B_DEAD]:  w_dec  = !w_zero;
        r_state[B_FAULT]: w_load = Fault_Clear;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_DEAD;
    end else if (r_flt) begin
      r_state <= S_FAULT;
    end else begin
      unique case (1'b1)
        r_state[B_IDLE]:  r_state <= req_target(w_req);
        r_state[B_HIGH]:  if (w_req != REQ_HIGH) r_state <= S_DEAD;
        r_state[B_LOW]:   if (w_req != REQ_LOW) r_state <= S_DEAD;
        r_state[B_DEAD]:  if (w_zero) r_state <= req_target(w_req);
        r_state[B_FAULT]: if (Fault_Clear) r_state <= S_DEAD;
        default:          r_state <= S_DEAD;
      endcase
    end
  end

  dead_time_counter #(
    .W       (CW),
    .RST_VAL (LOAD_VAL)
  ) u_cnt (
    .i_clk      (Clock),
    .i_rst_n    (Reset),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign Gate_High     = r_state[B_HIGH];
  assign Gate_Low      = r_state[B_LOW];
  assign Dead_Active   = r_state[B_DEAD];
  assign Fault_Latched = r_state[B_FAULT];

endmodule

// File: tb/tb_dead_time_generator.sv
// Bench for dead_time_generator: DEAD_TIME=4 vector table, 1/4/255 gap checks.
// Shared stimulus drives three instances; a monitor watches overlap and gaps.
module tb_dead_time_generator;

  localparam int DTS [3] = '{1, 4, 255};

  typedef struct {
    logic       hi, lo, en, flt, clr;
    logic [3:0] exp;
  } vec_t;

  logic Clock, Reset;
  logic hi, lo, en, flt, clr;
  logic gh [3];
  logic gl [3];
  logic da [3];
  logic fl [3];

  int n_vec = 0;
  int n_bad = 0;

  vec_t tbl [$];

  dead_time_generator #(.DEAD_TIME(1)) u_dt1 (
    .Clock(Clock), .Reset(Reset),
    .PWM_High(hi), .PWM_Low(lo), .Enable(en),
    .Fault(flt), .Fault_Clear(clr),
    .Gate_High(gh[0]), .Gate_Low(gl[0]),
    .Dead_Active(da[0]), .Fault_Latched(fl[0])
  );

  dead_time_generator #(.DEAD_TIME(4)) u_dt4 (
    .Clock(Clock), .Reset(Reset),
    .PWM_High(hi), .PWM_Low(lo), .Enable(en),
    .Fault(flt), .Fault_Clear(clr),
    .Gate_High(gh[1]), .Gate_Low(gl[1]),
    .Dead_Active(da[1]), .Fault_Latched(fl[1])
  );

  dead_time_generator #(.DEAD_TIME(255)) u_dt255 (
    .Clock(Clock), .Reset(Reset),
    .PWM_High(hi), .PWM_Low(lo), .Enable(en),
    .Fault(flt), .Fault_Clear(clr),
    .Gate_High(gh[2]), .Gate_Low(gl[2]),
    .Dead_Active(da[2]), .Fault_Latched(fl[2])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [3:0] outs(input int k);
    return {gh[k], gl[k], da[k], fl[k]};
  endfunction

  task automatic chk(input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got gh/gl/da/fl=%b, required %b", nm, got, exp);
    end
  endtask

  function automatic void add(
    input logic h, l, e, f, c,
    input logic [3:0] x, input int n
  );
    vec_t v;
    v.hi = h; v.lo = l; v.en = e; v.flt = f; v.clr = c; v.exp = x;
    repeat (n) tbl.push_back(v);
  endfunction

  // Overlap and minimum both-low gap before every gate rise, all instances.
  int   run [3] = '{0, 0, 0};
  logic pgh [3] = '{1'b0, 1'b0, 1'b0};
  logic pgl [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge Clock) begin
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (gh[k] && gl[k]) begin
        n_bad++;
        $display("FAIL overlap dt%0d: gh=1 gl=1, required not both 1",
                 DTS[k]);
      end
      if ((gh[k] && !pgh[k]) || (gl[k] && !pgl[k])) begin
        n_vec++;
        if (run[k] < DTS[k]) begin
          n_bad++;
          $display("FAIL gap dt%0d: low cycles=%0d, required >=%0d",
                   DTS[k], run[k], DTS[k]);
        end
      end
      if (!gh[k] && !gl[k]) run[k]++;
      else run[k] = 0;
      pgh[k] = gh[k];
      pgl[k] = gl[k];
    end
  end

  int   cnt  [3];
  logic done [3];
  int   hold;
  int   r;

  initial begin
    Reset = 1'b0;
    hi = 1'b1; lo = 1'b0; en = 1'b1; flt = 1'b0; clr = 1'b0;

    //  hi lo en f  c   gh gl da fl
    add(1, 0, 1, 0, 0, 4'b0010, 3);
    add(1, 0, 1, 0, 0, 4'b1000, 1);
    add(0, 1, 1, 0, 0, 4'b1000, 1);
    add(0, 1, 1, 0, 0, 4'b0010, 4);
    add(0, 1, 1, 0, 0, 4'b0100, 1);
    add(1, 0, 1, 0, 0, 4'b0100, 1);
    add(1, 0, 1, 0, 0, 4'b0010, 4);
    add(1, 0, 1, 0, 0, 4'b1000, 1);
    add(0, 1, 1, 0, 0, 4'b1000, 1);
    add(0, 1, 1, 0, 0, 4'b0010, 1);
    add(1, 0, 1, 0, 0, 4'b0010, 3);
    add(1, 0, 1, 0, 0, 4'b1000, 1);
    add(1, 1, 1, 0, 0, 4'b1000, 1);
    add(1, 1, 1, 0, 0, 4'b0010, 4);
    add(1, 1, 1, 0, 0, 4'b0000, 5);
    add(1, 0, 1, 0, 0, 4'b0000, 1);
    add(1, 0, 1, 0, 0, 4'b1000, 1);
    add(0, 1, 1, 0, 0, 4'b1000, 1);
    add(0, 1, 1, 0, 0, 4'b0010, 4);
    add(0, 1, 1, 0, 0, 4'b0100, 1);
    add(0, 1, 1, 1, 0, 4'b0100, 1);
    add(0, 1, 1, 0, 0, 4'b0001, 4);
    add(0, 1, 1, 0, 1, 4'b0010, 1);
    add(0, 1, 1, 0, 0, 4'b0010, 3);
    add(0, 1, 1, 0, 0, 4'b0100, 1);
    add(0, 1, 1, 1, 1, 4'b0100, 1);
    add(0, 1, 1, 1, 1, 4'b0001, 1);
    add(0, 1, 1, 0, 1, 4'b0001, 1);
    add(0, 1, 1, 0, 1, 4'b0010, 1);
    add(0, 1, 1, 0, 0, 4'b0010, 3);
    add(0, 1, 1, 0, 0, 4'b0100, 1);
    add(0, 1, 0, 0, 0, 4'b0100, 1);
    add(0, 1, 0, 0, 0, 4'b0010, 4);
    add(0, 1, 0, 0, 0, 4'b0000, 1);

    repeat (3) @(negedge Clock);
    for (int k = 0; k < 3; k++) chk($sformatf("reset dt%0d", DTS[k]),
                                    outs(k), 4'b0010);
    Reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      hi = tbl[i].hi; lo = tbl[i].lo; en = tbl[i].en;
      flt = tbl[i].flt; clr = tbl[i].clr;
      @(posedge Clock);
      @(negedge Clock);
      chk($sformatf("vec%0d", i + 1), outs(1), tbl[i].exp);
    end

    // Reset mid-operation: gate drops without waiting for an edge.
    hi = 1'b1; lo = 1'b0; en = 1'b1; flt = 1'b0; clr = 1'b0;
    repeat (2) @(negedge Clock);
    chk("pre-reset high", outs(1), 4'b1000);
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1 chk("async reset", outs(1), 4'b0010);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clock);
      chk($sformatf("rst dead e%0d", i), outs(1), 4'b0010);
    end
    @(negedge Clock);
    chk("rst high e4", outs(1), 4'b1000);

    // Exact gap length for DEAD_TIME 1, 4 and 255.
    repeat (260) @(negedge Clock);
    for (int k = 0; k < 3; k++) chk($sformatf("settle dt%0d", DTS[k]),
                                    outs(k), 4'b1000);
    hi = 1'b0; lo = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; done[k] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge Clock);
      for (int k = 0; k < 3; k++) begin
        if (!done[k]) begin
          if (gl[k]) done[k] = 1'b1;
          else if (!gh[k]) cnt[k]++;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (!done[k] || cnt[k] != DTS[k]) begin
        n_bad++;
        $display("FAIL exact gap dt%0d: low cycles=%0d done=%b, required %0d",
                 DTS[k], cnt[k], done[k], DTS[k]);
      end
    end

    // Random traffic; the monitor does the checking.
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge Clock);
      if (hold == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 7) begin
          hi = !hi;
          lo = !hi;
        end else begin
          hi = 1'($urandom_range(0, 1));
          lo = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 3) == 0) hold = int'($urandom_range(1, 6));
        else hold = int'($urandom_range(1, 400));
      end else begin
        hold--;
      end
      en  = ($urandom_range(0, 299) != 0);
      flt = ($urandom_range(0, 999) == 0);
      clr = ($urandom_range(0, 7) == 0);
    end

    @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
